// File: rtl/layer_schedule_ctrl.sv
// layer_schedule_ctrl: walks buffer layers in order, streaming each loaded layer's read addresses to compute
module layer_schedule_ctrl #(
  parameter int NUM_LAYERS = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_wr_en,
  input  logic [2:0]              cfg_layer_id,
  input  logic [ADDR_WIDTH-3:0]   cfg_len,
  input  logic                    load_done,
  input  logic [2:0]              load_layer_id,
  input  logic                    start,
  input  logic [3:0]              num_layers,
  output logic                    busy,
  output logic                    seq_done,
  output logic [2:0]              active_layer,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_last,
  output logic                    layer_start,
  input  logic                    compute_done,
  output logic [NUM_LAYERS-1:0]   loaded_mask,
  output logic                    cfg_err
);
  localparam int LW = ADDR_WIDTH - 2;
  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** (ADDR_WIDTH - 3));
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [2:0] cur;
  logic [3:0] n, n_start;
  logic [LW-1:0] addr, len_cur;
  logic [LW-1:0] len [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] loaded, clr_mask, set_mask;
  logic last_n, skip, go, step, drop;
  assign len_cur = len[cur];
  assign last_n = {1'b0, cur} == n - 4'd1;
  assign n_start = num_layers > 4'd8 ? 4'd8 : num_layers;
  assign skip = state == WAIT_LOAD && len_cur == '0;
  assign go = state == WAIT_LOAD && len_cur != '0 && loaded[cur];
  assign step = skip || (state == DRAIN && compute_done);
  assign drop = busy && cfg_layer_id == cur;
  assign clr_mask = step ? NUM_LAYERS'(1) << cur : '0;
  assign set_mask = load_done ? NUM_LAYERS'(1) << load_layer_id : '0;
  assign loaded_mask = loaded;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start ? (n_start == 4'd0 ? DONE : WAIT_LOAD) : IDLE;
      WAIT_LOAD: nxt = skip ? (last_n ? DONE : WAIT_LOAD) : go ? STREAM : WAIT_LOAD;
      STREAM:    nxt = rd_ready && rd_last ? DRAIN : STREAM;
      DRAIN:     nxt = compute_done ? (last_n ? DONE : WAIT_LOAD) : DRAIN;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    seq_done = state == DONE;
    rd_valid = state == STREAM;
    rd_last = rd_valid && addr == len_cur - LW'(1);
    rd_addr = ADDR_WIDTH'(addr);
    active_layer = cur;
  end
  // addr returns to zero on the final handshake, so it is always 0 outside STREAM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= '0;
      n <= '0;
      addr <= '0;
      loaded <= '0;
      layer_start <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) len[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur <= '0;
        n <= n_start;
      end else if (step && !last_n) cur <= cur + 3'd1;
      if (rd_valid && rd_ready) addr <= rd_last ? '0 : addr + LW'(1);
      loaded <= (loaded & ~clr_mask) | set_mask;
      layer_start <= go;
      cfg_err <= cfg_wr_en && drop;
      if (cfg_wr_en && !drop) len[cfg_layer_id] <= cfg_len > MAX_LEN ? MAX_LEN : cfg_len;
    end
  end
endmodule

// File: doc/layer_schedule_ctrl.md
# layer_schedule_ctrl

Sequencer for the partitioned multi-layer weight/activation buffer. It holds per-layer lengths and "loaded" flags set by the host loader. On start it walks layers 0..num_layers-1 in order. For each layer it:
- waits until the layer's data is loaded,
- drives the buffer's layer select and a relative read-address stream to the compute datapath with a valid/ready handshake,
- waits for compute completion, then frees the slot for reloading.

It sits between the host load path, the unified layer buffer's read port and the systolic compute scheduler.

## Interface
- NUM_LAYERS, 8, number of buffer partitions; fixed at 8 (3-bit layer ids)
- ADDR_WIDTH, 16, buffer address width; per-layer stride is 2^(ADDR_WIDTH-3) words (8192)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_wr_en  in  1  write cfg_len into the length register of cfg_layer_id
- cfg_layer_id  in  3  layer being configured
- cfg_len  in  ADDR_WIDTH-2  layer length in words, 0..8192; values above 8192 saturate to 8192
- load_done  in  1  one-cycle pulse: host finished writing layer load_layer_id
- load_layer_id  in  3  layer whose load completed
- start  in  1  begin sequence; honoured only in IDLE
- num_layers  in  4  layers to run, sampled on start; 0 means none, values >8 clamp to 8
- busy  out  1  high in every state except IDLE
- seq_done  out  1  one-cycle pulse at end of sequence
- active_layer  out  3  layer select to the buffer read port
- rd_addr  out  ADDR_WIDTH  relative read address, zero-extended
- rd_valid  out  1  rd_addr valid; buffer rd_data is valid in the same cycle (combinational read)
- rd_ready  in  1  datapath accepts the current word
- rd_last  out  1  current word is the last of the layer
- layer_start  out  1  one-cycle pulse in the first STREAM cycle of a layer
- compute_done  in  1  datapath finished the layer; honoured only in DRAIN
- loaded_mask  out  NUM_LAYERS  per-layer loaded flags
- cfg_err  out  1  one-cycle pulse: cfg write to active_layer while busy was dropped

## Operation
States:
- **IDLE**
  - start → WAIT_LOAD; cur=0, n latched.
  - If latched n==0 → DONE instead.
- **WAIT_LOAD**
  - len[cur]==0: layer is skipped. Clear loaded[cur], then advance.
  - Otherwise, when loaded[cur]=1 → STREAM with addr=0.
- **STREAM**
  - rd_valid=1; rd_addr=addr; rd_last=(addr==len[cur]-1).
  - On rd_valid&rd_ready: addr+1. If the handshake was on rd_last → DRAIN.
  - With rd_ready low, rd_addr/rd_last are held.
- **DRAIN**
  - rd_valid=0. On compute_done: clear loaded[cur], then advance.
- **Advance**
  - If cur==n-1 → DONE, else cur+1 → WAIT_LOAD.
- **DONE**
  - seq_done=1 for one cycle → IDLE.

Rules:
- active_layer=cur in all non-IDLE states; it holds its last value in IDLE.
- load_done sets loaded[load_layer_id] in any state.
- If load_done sets and the controller clears the same bit in the same cycle, the set wins.
- cfg writes are accepted in any state, except a write to active_layer while busy: that write is dropped and cfg_err is pulsed.
- len[] is not reset by the sequence; it persists until rewritten or rst_n.
- start while busy is ignored.
- compute_done outside DRAIN is ignored.

## Timing
- Reset (rst_n=0 at clk edge) forces:
  - state=IDLE;
  - busy, seq_done, rd_valid, rd_last, layer_start, cfg_err = 0;
  - active_layer, rd_addr = 0;
  - loaded_mask = 0 and all len = 0.
- Reset mid-sequence aborts immediately with no seq_done.
- All outputs are registered or decoded from registered state; there is no combinational path from rd_ready to rd_valid.
- start at edge k → busy=1 and WAIT_LOAD from cycle k+1.
- WAIT_LOAD with loaded already set → STREAM next cycle. The first word is presented in that cycle, with layer_start=1.
- At full throughput (rd_ready=1 continuously) a layer of L words occupies exactly L STREAM cycles.
- compute_done at edge k in DRAIN → WAIT_LOAD (or DONE) at k+1; loaded bit cleared at k+1.
- Zero-length layer costs 1 WAIT_LOAD cycle.
- Minimum overhead per layer is 1 WAIT_LOAD + 1 DRAIN cycle, plus compute_done wait.
- The address counter is ADDR_WIDTH-2 bits. len=8192 reaches addr 8191 with no wrap, since rd_last ends the layer first.

## Test plan
- **Basic run:** len[0]=4, len[1]=2, both load_done pulsed, start with num_layers=2, rd_ready=1, compute_done 3 cycles after each rd_last.
  - Required: addresses 0,1,2,3 with active_layer=0, rd_last on 3; then 0,1 with active_layer=1.
  - layer_start pulses twice; seq_done once; loaded_mask returns to 0.
- **Backpressure:** len[0]=3, rd_ready toggling 1,0,0,1,1.
  - Required: each address held while ready is low; exactly 3 handshakes; rd_last only with addr=2.
- **Load gating:** start with num_layers=2, loaded only layer 0; load_done for layer 1 issued 20 cycles after layer 0's compute_done.
  - Required: rd_valid=0 and active_layer=1 in WAIT_LOAD until 1 cycle after load_done.
- **Skip and clamp:** len[1]=0, num_layers=12, all loaded.
  - Required: layer 1 produces no layer_start; layers 0,2..7 run; seq_done after layer 7.
  - cfg_len=9000 saturates to an 8192-word stream.
- **Collisions:** load_done for cur in the same cycle as compute_done → loaded bit stays 1.
  - cfg write to active_layer during STREAM → cfg_err pulse, len unchanged.
  - start while busy → ignored.
- **Reset:** rst_n=0 mid-STREAM → next cycle all outputs 0, loaded_mask=0, no seq_done; a fresh start runs normally.
